// File: rtl/nfc_multi_page_copy.sv
// NAND-to-NAND page copy engine: streams each byte read from flash A straight into flash B's program buffer.
// Define NFC_STATUS_CHECK_EN to add a 70h status read after each program and abort the run on a program fail.
module nfc_multi_page_copy #(
  parameter int PAGE_BYTES  = 2048,
  parameter int ADDR_CYCLES = 5,
  parameter int TWB_CLKS    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [8*(ADDR_CYCLES-2)-1:0]  src_row,
  input  logic [8*(ADDR_CYCLES-2)-1:0]  dst_row,
  input  logic [15:0]                   num_pages,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  inout  wire  [7:0]                    F_IO_A,
  output logic                          F_CLE_A,
  output logic                          F_ALE_A,
  output logic                          F_REN_A,
  output logic                          F_WEN_A,
  input  logic                          F_RB_A,
  inout  wire  [7:0]                    F_IO_B,
  output logic                          F_CLE_B,
  output logic                          F_ALE_B,
  output logic                          F_REN_B,
  output logic                          F_WEN_B,
  input  logic                          F_RB_B
);

  localparam int ROW_BITS = 8 * (ADDR_CYCLES - 2);
  localparam int CNT_MAX  = (2 * PAGE_BYTES > TWB_CLKS) ? 2 * PAGE_BYTES : TWB_CLKS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] STREAM_LAST = CNT_W'(2 * PAGE_BYTES);
  localparam logic [CNT_W-1:0] ADDR_LAST   = CNT_W'(ADDR_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWB_CNT     = CNT_W'(TWB_CLKS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_A_CMD,
    S_A_ADDR,
    S_A_CONF,
    S_A_WAIT,
    S_B_CMD,
    S_B_ADDR,
    S_STREAM,
    S_B_CONF,
    S_B_WAIT,
    S_NEXT
`ifdef NFC_STATUS_CHECK_EN
    ,
    S_ST_CMD,
    S_ST_RD
`endif
  } state_t;

  state_t                state_reg, state_next;
  logic                  phase_reg, phase_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [ROW_BITS-1:0]   src_row_reg, src_row_next;
  logic [ROW_BITS-1:0]   dst_row_reg, dst_row_next;
  logic [15:0]           remaining_reg, remaining_next;
  logic [7:0]            data_reg, data_next;
  logic                  done_reg, done_next;
`ifdef NFC_STATUS_CHECK_EN
  logic                  err_reg, err_next;
`endif

  logic       cle_a, ale_a, ren_a, wen_a, io_a_oe;
  logic       cle_b, ale_b, ren_b, wen_b, io_b_oe;
  logic [7:0] io_a_out, io_b_out;

  // Address cycle bytes: two zero column bytes, then the row LSB first.
  logic [7:0] src_addr_bytes [ADDR_CYCLES];
  logic [7:0] dst_addr_bytes [ADDR_CYCLES];
  logic [7:0] src_addr_byte, dst_addr_byte;

  generate
    for (genvar gi = 0; gi < ADDR_CYCLES; gi++) begin : g_addr
      if (gi < 2) begin : g_col
        assign src_addr_bytes[gi] = 8'h00;
        assign dst_addr_bytes[gi] = 8'h00;
      end else begin : g_row
        assign src_addr_bytes[gi] = src_row_reg[8*(gi-2) +: 8];
        assign dst_addr_bytes[gi] = dst_row_reg[8*(gi-2) +: 8];
      end
    end
  endgenerate

  always_comb begin
    src_addr_byte = 8'h00;
    dst_addr_byte = 8'h00;
    for (int i = 0; i < ADDR_CYCLES; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        src_addr_byte = src_addr_bytes[i];
        dst_addr_byte = dst_addr_bytes[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      phase_reg     <= 1'b0;
      cnt_reg       <= '0;
      src_row_reg   <= '0;
      dst_row_reg   <= '0;
      remaining_reg <= '0;
      data_reg      <= 8'h00;
      done_reg      <= 1'b0;
`ifdef NFC_STATUS_CHECK_EN
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cnt_reg       <= cnt_next;
      src_row_reg   <= src_row_next;
      dst_row_reg   <= dst_row_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
`ifdef NFC_STATUS_CHECK_EN
      err_reg       <= err_next;
`endif
    end
  end

  // Write cycles use phase 0 (WEN low) and phase 1 (WEN high); strobes decode from state.
  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    cnt_next       = cnt_reg;
    src_row_next   = src_row_reg;
    dst_row_next   = dst_row_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    done_next      = 1'b0;
`ifdef NFC_STATUS_CHECK_EN
    err_next       = err_reg;
`endif
    cle_a = 1'b0; ale_a = 1'b0; ren_a = 1'b1; wen_a = 1'b1; io_a_oe = 1'b0; io_a_out = 8'h00;
    cle_b = 1'b0; ale_b = 1'b0; ren_b = 1'b1; wen_b = 1'b1; io_b_oe = 1'b0; io_b_out = 8'h00;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          src_row_next   = src_row;
          dst_row_next   = dst_row;
          remaining_next = num_pages;
          phase_next     = 1'b0;
          cnt_next       = '0;
`ifdef NFC_STATUS_CHECK_EN
          err_next       = 1'b0;
`endif
          if (num_pages == 16'd0) done_next = 1'b1;
          else                    state_next = S_A_CMD;
        end
      end
      S_A_CMD: begin
        cle_a = 1'b1; io_a_oe = 1'b1; io_a_out = 8'h00; wen_a = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = S_A_ADDR;
          cnt_next   = '0;
        end
      end
      S_A_ADDR: begin
        ale_a = 1'b1; io_a_oe = 1'b1; io_a_out = src_addr_byte; wen_a = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          if (cnt_reg == ADDR_LAST) state_next = S_A_CONF;
          cnt_next = (cnt_reg == ADDR_LAST) ? '0 : cnt_reg + 1'b1;
        end
      end
      S_A_CONF: begin
        cle_a = 1'b1; io_a_oe = 1'b1; io_a_out = 8'h30; wen_a = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = S_A_WAIT;
          cnt_next   = '0;
        end
      end
      S_A_WAIT: begin
        // R/B is not trusted until tWB has elapsed after the confirm command.
        if (cnt_reg < TWB_CNT) cnt_next = cnt_reg + 1'b1;
        else if (F_RB_A)       state_next = S_B_CMD;
      end
      S_B_CMD: begin
        cle_b = 1'b1; io_b_oe = 1'b1; io_b_out = 8'h80; wen_b = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = S_B_ADDR;
          cnt_next   = '0;
        end
      end
      S_B_ADDR: begin
        ale_b = 1'b1; io_b_oe = 1'b1; io_b_out = dst_addr_byte; wen_b = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          if (cnt_reg == ADDR_LAST) state_next = S_STREAM;
          cnt_next = (cnt_reg == ADDR_LAST) ? '0 : cnt_reg + 1'b1;
        end
      end
      S_STREAM: begin
        // Even counts read A, odd counts write the byte captured on the previous edge into B.
        ren_a    = ~(~cnt_reg[0] && (cnt_reg != STREAM_LAST));
        wen_b    = ~cnt_reg[0];
        io_b_oe  = (cnt_reg != '0);
        io_b_out = data_reg;
        if (!ren_a) data_next = F_IO_A;
        if (cnt_reg == STREAM_LAST) begin
          state_next = S_B_CONF;
          phase_next = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_B_CONF: begin
        cle_b = 1'b1; io_b_oe = 1'b1; io_b_out = 8'h10; wen_b = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) begin
          state_next = S_B_WAIT;
          cnt_next   = '0;
        end
      end
      S_B_WAIT: begin
        if (cnt_reg < TWB_CNT) cnt_next = cnt_reg + 1'b1;
`ifdef NFC_STATUS_CHECK_EN
        else if (F_RB_B)       state_next = S_ST_CMD;
`else
        else if (F_RB_B)       state_next = S_NEXT;
`endif
      end
`ifdef NFC_STATUS_CHECK_EN
      S_ST_CMD: begin
        cle_b = 1'b1; io_b_oe = 1'b1; io_b_out = 8'h70; wen_b = phase_reg;
        phase_next = ~phase_reg;
        if (phase_reg) state_next = S_ST_RD;
      end
      S_ST_RD: begin
        ren_b = 1'b0;
        if (F_IO_B[0]) begin
          err_next   = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else begin
          state_next = S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        src_row_next   = src_row_reg + ROW_BITS'(1);
        dst_row_next   = dst_row_reg + ROW_BITS'(1);
        remaining_next = remaining_reg - 16'd1;
        phase_next     = 1'b0;
        cnt_next       = '0;
        if (remaining_reg == 16'd1) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = S_A_CMD;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign F_IO_A  = io_a_oe ? io_a_out : 8'hzz;
  assign F_IO_B  = io_b_oe ? io_b_out : 8'hzz;
  assign F_CLE_A = cle_a;
  assign F_ALE_A = ale_a;
  assign F_REN_A = ren_a;
  assign F_WEN_A = wen_a;
  assign F_CLE_B = cle_b;
  assign F_ALE_B = ale_b;
  assign F_REN_B = ren_b;
  assign F_WEN_B = wen_b;

  assign busy = (state_reg != S_IDLE);
  assign done = done_reg;
`ifdef NFC_STATUS_CHECK_EN
  assign err  = err_reg;
`else
  assign err  = 1'b0;
`endif

endmodule

// File: doc/nfc_multi_page_copy.md
Name: nfc_multi_page_copy

Overview:
- Parametrised NAND-to-NAND page copy engine that moves a run of pages from flash A to flash B.
- Uses large-page commands: read 00h/30h, program 80h/10h, optional status 70h.
- Streams each byte read from A straight into B's program buffer. No page RAM is used.
- Sits between the top-level sequencer (start/done) and the two raw NAND pin interfaces.

Parameters:
- PAGE_BYTES, 2048, data bytes per page (>=2).
- ADDR_CYCLES, 5, address cycles per command: 2 column bytes (always 00h) plus ADDR_CYCLES-2 row bytes, LSB first. Range 3..6.
- TWB_CLKS, 2, minimum clocks after a 30h/10h command before F_RB_x is sampled.
- Derived localparam ROW_BITS = 8*(ADDR_CYCLES-2).

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-clk pulse; accepted only when busy=0
- src_row  in  ROW_BITS  first source row on A; sampled at start
- dst_row  in  ROW_BITS  first destination row on B; sampled at start
- num_pages  in  16  pages to copy; sampled at start
- busy  out  1  high from the clk after an accepted start until done
- done  out  1  one-clk pulse at end of run
- err  out  1  sticky program-fail flag; cleared on accepted start
- F_IO_A  inout  8  flash A data bus
- F_CLE_A, F_ALE_A, F_REN_A, F_WEN_A  out  1 each  flash A strobes
- F_RB_A  in  1  flash A ready(1)/busy(0)
- F_IO_B  inout  8  flash B data bus
- F_CLE_B, F_ALE_B, F_REN_B, F_WEN_B  out  1 each  flash B strobes
- F_RB_B  in  1  flash B ready(1)/busy(0)

Behaviour:
- Reset, and the clk after any rst=1 including mid-operation:
  - CLE=0, ALE=0, REN=1, WEN=1 on both flashes.
  - Both IO buses hi-Z.
  - busy=0, done=0, err=0. FSM returns to IDLE.
  - No attempt is made to finish an in-flight flash command.
- Write bus cycle (command/address/data) takes 2 clk:
  - clk0: WEN=0, IO driven.
  - clk1: WEN=1, IO still driven.
  - CLE/ALE held for both clks.
- Read bus cycle: REN=0 for one clk. F_IO is captured at the edge ending that clk, then REN=1.
- FSM sequence:
  - IDLE -> on start with num_pages=0: done pulses on the next clk, busy stays 0.
  - Otherwise the per-page sequence is:
    - A_CMD: 00h to A.
    - A_ADDR: ADDR_CYCLES bytes to A.
    - A_CONF: 30h to A.
    - A_WAIT: wait TWB_CLKS clks, then until F_RB_A=1.
    - B_CMD: 80h to B.
    - B_ADDR: ADDR_CYCLES bytes to B.
    - STREAM
    - B_CONF: 10h to B.
    - B_WAIT: wait TWB_CLKS clks, then until F_RB_B=1.
    - [STATUS]
    - NEXT
- STREAM, per byte:
  - clk n: REN_A=0.
  - clk n+1: REN_A=1; captured byte on F_IO_B; WEN_B=0.
  - clk n+2: WEN_B=1 while REN_A=0 for the next byte.
  - Steady state 2 clk/byte. Stream length = 2*PAGE_BYTES+1 clks.
  - F_IO_A is never driven during STREAM.
- NEXT:
  - Increment row counters, mod 2^ROW_BITS (wrap allowed, no flag).
  - Decrement remaining count; when it reaches 0, go to IDLE with a done pulse and busy=0 in the same clk.
- Only one flash strobe group toggles at a time except in STREAM. Idle strobes sit at reset values.
- start while busy=1 is ignored. RB low outside a WAIT state is ignored.

Optional Feature:
- Macro NFC_STATUS_CHECK_EN.
- Defined: after B_WAIT, issue 70h to B, then one read cycle on B with F_IO_B hi-Z.
  - If status bit0=1: set err, then skip directly to IDLE with a done pulse. Remaining pages are abandoned.
  - If bit0=0: go to NEXT.
- Undefined: the STATUS state does not exist, err is tied 0, and B_WAIT goes straight to NEXT.

Test Plan:
- Reset mid-STREAM: assert rst for 1 clk at byte 100 -> next clk all WEN/REN=1, CLE/ALE=0, IO hi-Z, busy=0; a later start restarts cleanly.
- num_pages=0, start pulse -> done=1 on the clk after start, no strobe activity, busy never 1.
- PAGE_BYTES=4, ADDR_CYCLES=5, src_row=0x0012, dst_row=0x0034, num_pages=1, A model returns 11h,22h,33h,44h:
  - B sees 80h, then 00h,00h,34h,00h,00h under ALE, then 11h,22h,33h,44h, then 10h.
  - done follows F_RB_B rising.
- num_pages=3 from src_row=0xFFFE with ROW_BITS=24 -> source rows 0xFFFE, 0xFFFF, 0x10000; done after third page only.
- F_RB_A held low for 50 clks after 30h -> no REN_A activity until the clk after F_RB_A=1; no RB sampling within TWB_CLKS of 30h.
- With NFC_STATUS_CHECK_EN, B status=01h on page 1 of 2 -> err=1, done pulse, page 2 never addressed; err clears on the next accepted start.
